// File: rtl/smpc_pad_scan_if.sv
// -----------------------------------------------------------------------------
// smpc_pad_scan_if
// Bundle between the SMPC pad scanner and its surroundings: the command-engine
// side (CE, START, JOY*, PRES*, BUSY, DONE) and the P1/P2 port pins.
//   master : drives CE/START and the pin inputs, observes everything else
//   slave  : the scanner itself
// -----------------------------------------------------------------------------
interface smpc_pad_scan_if;
    logic        CE;
    logic        START;
    logic [6:0]  P1I;
    logic [6:0]  P2I;
    logic [6:0]  P1O;
    logic [6:0]  P2O;
    logic [6:0]  P1OE;
    logic [6:0]  P2OE;
    logic [15:0] JOY1;
    logic [15:0] JOY2;
    logic        PRES1;
    logic        PRES2;
    logic        BUSY;
    logic        DONE;

    modport master (
        output CE, START, P1I, P2I,
        input  P1O, P2O, P1OE, P2OE, JOY1, JOY2, PRES1, PRES2, BUSY, DONE
    );

    modport slave (
        input  CE, START, P1I, P2I,
        output P1O, P2O, P1OE, P2OE, JOY1, JOY2, PRES1, PRES2, BUSY, DONE
    );
endinterface

// File: rtl/smpc_pad_scan.sv
// -----------------------------------------------------------------------------
// smpc_pad_scan
// Saturn digital-pad scanner for both peripheral ports. Steps the TH/TR select
// lines through four codes, samples one data nibble per code after SETTLE CE
// ticks, and commits one active-low 16-bit word plus a presence flag per port.
// Ports:
//   CLK   system clock
//   RST   synchronous, active-high reset
//   bus   smpc_pad_scan_if.slave: CE, START, P1I/P2I pin inputs, P1O/P2O
//         select outputs (TH=[6], TR=[5]), P1OE/P2OE, JOY1/JOY2, PRES1/PRES2,
//         BUSY, DONE
// -----------------------------------------------------------------------------
module smpc_pad_scan #(
    parameter int SETTLE = 2   // 1..255
) (
    input  logic             CLK,
    input  logic             RST,
    smpc_pad_scan_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_WAIT,
        ST_END
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1:0]      k_q, k_d;
    logic [1:0]      sel_q, sel_d;        // {TH, TR}
    logic [3:0][3:0] sh1_q, sh1_d;        // shadow nibbles n3..n0, port 1
    logic [3:0][3:0] sh2_q, sh2_d;        // shadow nibbles n3..n0, port 2
    logic [15:0]     joy1_q, joy1_d;
    logic [15:0]     joy2_q, joy2_d;
    logic            pres1_q, pres1_d;
    logic            pres2_q, pres2_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Only D3..D0 carry pad data; the upper pin inputs are deliberately ignored.
    logic unused_pins;
    assign unused_pins = ^{bus.P1I[6:4], bus.P2I[6:4]};

    function automatic logic [1:0] sel_code(input logic [1:0] k);
        case (k)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // A digital pad identifies itself with 3'b100 in the low bits of n3.
    function automatic logic pad_present(input logic [3:0][3:0] n);
        return n[3][2:0] == 3'b100;
    endfunction

    function automatic logic [15:0] pad_word(input logic [3:0][3:0] n);
        return pad_present(n) ? {n[2], n[1], n[0], n[3]} : 16'hFFFF;
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        sel_d   = sel_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        pres1_d = pres1_q;
        pres2_d = pres2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;                   // DONE lasts exactly one CLK cycle

        if (bus.CE) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        k_d     = 2'd0;
                        busy_d  = 1'b1;
                        state_d = ST_SEL;
                    end
                end
                ST_SEL: begin
                    sel_d   = sel_code(k_q);
                    cnt_d   = 8'(SETTLE);
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        sh1_d[k_q] = bus.P1I[3:0];
                        sh2_d[k_q] = bus.P2I[3:0];
                        if (k_q == 2'd3) begin
                            state_d = ST_END;
                        end else begin
                            k_d     = k_q + 2'd1;
                            state_d = ST_SEL;
                        end
                    end
                end
                default: begin            // ST_END
                    joy1_d  = pad_word(sh1_q);
                    joy2_d  = pad_word(sh2_q);
                    pres1_d = pad_present(sh1_q);
                    pres2_d = pad_present(sh2_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    sel_d   = 2'b11;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the shadow nibbles are a tiny register file, but they are
            // reset anyway so a scan cut short by RST leaves no stale data.
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            k_q     <= 2'd0;
            sel_q   <= 2'b11;
            sh1_q   <= '1;
            sh2_q   <= '1;
            joy1_q  <= 16'hFFFF;
            joy2_q  <= 16'hFFFF;
            pres1_q <= 1'b0;
            pres2_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            sel_q   <= sel_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            pres1_q <= pres1_d;
            pres2_q <= pres2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.P1O   = {sel_q, 5'b0};
    assign bus.P2O   = {sel_q, 5'b0};
    assign bus.P1OE  = 7'h60;
    assign bus.P2OE  = 7'h60;
    assign bus.JOY1  = joy1_q;
    assign bus.JOY2  = joy2_q;
    assign bus.PRES1 = pres1_q;
    assign bus.PRES2 = pres2_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;

endmodule

// File: tb/tb_smpc_pad_scan.sv
// -----------------------------------------------------------------------------
// tb_smpc_pad_scan
// Directed bench for smpc_pad_scan. dut_a uses SETTLE=2 with CE on every
// clock; dut_b uses SETTLE=5 with CE on one clock in three. Port 1 of each
// sees a pad model answering the select code; port 2 floats at 7'h7F.
// -----------------------------------------------------------------------------
module tb_smpc_pad_scan;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done;

    always #5 CLK = ~CLK;

    smpc_pad_scan_if a_if ();
    smpc_pad_scan_if b_if ();

    smpc_pad_scan #(.SETTLE(2)) dut_a (.CLK(CLK), .RST(RST), .bus(a_if.slave));
    smpc_pad_scan #(.SETTLE(5)) dut_b (.CLK(CLK), .RST(RST), .bus(b_if.slave));

    // Pad model: nibble returned for each {TH,TR} code.
    function automatic logic [3:0] pad_nib(input logic [1:0] sel);
        case (sel)
            2'b00:   return 4'hE;
            2'b10:   return 4'hD;
            2'b01:   return 4'h7;
            default: return 4'h4;
        endcase
    endfunction

    assign a_if.P1I = {3'b111, pad_nib(a_if.P1O[6:5])};
    assign a_if.P2I = 7'h7F;
    assign b_if.P1I = {3'b111, pad_nib(b_if.P1O[6:5])};
    assign b_if.P2I = 7'h7F;

    // Expected select code after CE tick t of a SETTLE=2 scan.
    function automatic logic [1:0] exp_sel(input int t);
        if (t == 0) return 2'b11;
        case ((t - 1) / 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_a(input logic st);
        @(negedge CLK);
        a_if.CE = 1'b1;
        a_if.START = st;
        @(posedge CLK);
        #1;
        a_if.CE = 1'b0;
        a_if.START = 1'b0;
    endtask

    task automatic tick_b(input logic st);
        @(negedge CLK);
        b_if.CE = 1'b1;
        b_if.START = st;
        @(posedge CLK);
        #1;
        b_if.CE = 1'b0;
        b_if.START = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        a_if.CE = 1'b0; a_if.START = 1'b0;
        b_if.CE = 1'b0; b_if.START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        check("rst_p1o",   16'(a_if.P1O),  16'h0060);
        check("rst_p2o",   16'(a_if.P2O),  16'h0060);
        check("rst_p1oe",  16'(a_if.P1OE), 16'h0060);
        check("rst_p2oe",  16'(a_if.P2OE), 16'h0060);
        check("rst_joy1",  a_if.JOY1,      16'hFFFF);
        check("rst_joy2",  a_if.JOY2,      16'hFFFF);
        check("rst_pres1", 16'(a_if.PRES1), 16'h0);
        check("rst_pres2", 16'(a_if.PRES2), 16'h0);
        check("rst_busy",  16'(a_if.BUSY),  16'h0);
        check("rst_done",  16'(a_if.DONE),  16'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Full scan, SETTLE=2, extra STARTs at ticks 5 and 10 must be ignored
        for (int t = 0; t <= 17; t++) begin
            tick_a(t == 0 || t == 5 || t == 10);
            check($sformatf("sel_p1o_t%0d", t), 16'(a_if.P1O), 16'({exp_sel(t), 5'b0}));
            check($sformatf("sel_p2o_t%0d", t), 16'(a_if.P2O), 16'({exp_sel(t), 5'b0}));
            check($sformatf("busy_t%0d", t), 16'(a_if.BUSY), 16'(t < 17));
            check($sformatf("done_t%0d", t), 16'(a_if.DONE), 16'(t == 17));
        end
        check("scan_joy1",  a_if.JOY1,       16'h7DE4);
        check("scan_pres1", 16'(a_if.PRES1), 16'h1);
        check("scan_joy2",  a_if.JOY2,       16'hFFFF);
        check("scan_pres2", 16'(a_if.PRES2), 16'h0);
        check("scan_p1oe",  16'(a_if.P1OE),  16'h0060);
        @(posedge CLK);
        #1;
        check("done_width", 16'(a_if.DONE), 16'h0);
        // No queued scan from the ignored STARTs
        n_done = 0;
        for (int t = 0; t < 20; t++) begin
            tick_a(1'b0);
            if (a_if.DONE || a_if.BUSY) n_done++;
        end
        check("no_queued_scan", 16'(n_done), 16'd0);

        // RST at tick 9 of a scan
        for (int t = 0; t <= 8; t++) tick_a(t == 0);
        check("pre_rst_busy", 16'(a_if.BUSY), 16'h1);
        @(negedge CLK);
        RST = 1'b1;
        a_if.CE = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_busy",  16'(a_if.BUSY),  16'h0);
        check("midrst_done",  16'(a_if.DONE),  16'h0);
        check("midrst_p1o",   16'(a_if.P1O),   16'h0060);
        check("midrst_joy1",  a_if.JOY1,       16'hFFFF);
        check("midrst_pres1", 16'(a_if.PRES1), 16'h0);
        @(negedge CLK);
        RST = 1'b0;
        a_if.CE = 1'b0;
        n_done = 0;
        for (int t = 0; t < 12; t++) begin
            tick_a(1'b0);
            if (a_if.DONE) n_done++;
        end
        check("midrst_no_done", 16'(n_done), 16'd0);
        check("midrst_joy1_hold", a_if.JOY1, 16'hFFFF);
        // Next START completes normally
        n_done = 0;
        for (int t = 0; t <= 17; t++) begin
            tick_a(t == 0);
            if (a_if.DONE) n_done++;
        end
        check("rescan_done_at_17", 16'(a_if.DONE), 16'h1);
        check("rescan_done_count", 16'(n_done), 16'd1);
        check("rescan_joy1", a_if.JOY1, 16'h7DE4);

        // SETTLE=5, CE on one clock in three
        n_done = 0;
        for (int t = 0; t <= 29; t++) begin
            tick_b(t == 0);
            if (b_if.DONE) n_done++;
            check($sformatf("b_done_t%0d", t), 16'(b_if.DONE), 16'(t == 29));
            check($sformatf("b_busy_t%0d", t), 16'(b_if.BUSY), 16'(t < 29));
            @(posedge CLK);
            #1;
            if (t == 29) check("b_done_width", 16'(b_if.DONE), 16'h0);
            @(posedge CLK);
        end
        check("b_done_count", 16'(n_done), 16'd1);
        check("b_joy1",  b_if.JOY1,       16'h7DE4);
        check("b_pres1", 16'(b_if.PRES1), 16'h1);
        check("b_joy2",  b_if.JOY2,       16'hFFFF);
        check("b_pres2", 16'(b_if.PRES2), 16'h0);
        check("b_p1o",   16'(b_if.P1O),   16'h0060);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
